int_controller: RTL

Four-source interrupt controller that sequences interrupt entry and exit for the 16-bit processor datapath. It detects rising edges on device request lines and holds them as pending bits. It applies a mask and a fixed priority, and presents one request at a time to the datapath with a handler vector. It uses an intr/intAck/intRet handshake and allows one interrupt in service at a time, with no nesting.

---
 rtl/int_ctrl_pkg.sv | 16 +
 rtl/int_prio_enc.sv | 17 +
 rtl/int_controller.sv | 97 +++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and helpers for the interrupt controller
package int_ctrl_pkg;
  localparam int N_SRC = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  function automatic logic [31:0] default_vec(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input int idx);
    return base + 32'(idx) * stride;
  endfunction
endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder over the eligible set
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [1:0]       id
);
  always_comb begin
    any = |req;
    id  = 2'd0;
    if (req[0])      id = 2'd0;
    else if (req[1]) id = 2'd1;
    else if (req[2]) id = 2'd2;
    else if (req[3]) id = 2'd3;
  end
endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - four-source edge-triggered interrupt controller
// with mask, fixed priority, vector table and intr/intAck/intRet handshake
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] VEC_BASE   = 'h0010,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 'h0010
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [3:0]       irq,
  input  logic             cfgWrite,
  input  logic [1:0]       cfgSel,
  input  logic [WIDTH-1:0] cfgData,
  input  logic             maskWrite,
  input  logic [3:0]       maskData,
  input  logic             intAck,
  input  logic             intRet,
  output logic             intr,
  output logic [1:0]       intLvl,
  output logic [WIDTH-1:0] intVector,
  output logic             busy,
  output logic [3:0]       pending
);
  state_t           state;
  logic [3:0]       irq_q;
  logic [3:0]       mask;
  logic [WIDTH-1:0] vec_tbl [N_SRC];

  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] ack_clr;
  logic       win_any;
  logic [1:0] win_id;

  assign rise     = irq & ~irq_q;
  assign eligible = pending & ~mask;
  // Only an accepted acknowledge retires the presented source.
  assign ack_clr  = (state == REQ && intAck) ? (4'b0001 << intLvl) : 4'b0000;

  int_prio_enc u_prio_enc (
    .req (eligible),
    .any (win_any),
    .id  (win_id)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      intr      <= 1'b0;
      busy      <= 1'b0;
      intLvl    <= 2'd0;
      intVector <= '0;
      pending   <= 4'b0000;
      mask      <= 4'b0000;
      irq_q     <= 4'b0000;
      for (int i = 0; i < N_SRC; i++)
        vec_tbl[i] <= WIDTH'(default_vec(32'(VEC_BASE), 32'(VEC_STRIDE), i));
    end else begin
      irq_q <= irq;
      // A fresh edge on the acknowledged source wins over its clear.
      pending <= (pending & ~ack_clr) | rise;
      if (maskWrite) mask <= maskData;
      if (cfgWrite)  vec_tbl[cfgSel] <= cfgData;

      case (state)
        IDLE: begin
          if (win_any) begin
            state     <= REQ;
            intr      <= 1'b1;
            intLvl    <= win_id;
            intVector <= vec_tbl[win_id];
          end
        end
        REQ: begin
          if (intAck) begin
            state <= SERVICE;
            intr  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SERVICE: begin
          if (intRet) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
